// File: rtl/pa_dtu_cdc_hs_src.sv
// Source-domain half of the DTU 4-phase req/ack crossing: a 2-entry event FIFO
// feeding a level request (req_lvl + stable req_data) toward the destination synchronizer.
module pa_dtu_cdc_hs_src #(
    parameter int DW     = 32,
    parameter int TO_CYC = 0
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          evt_vld,
    input  logic [DW-1:0] evt_data,
    output logic          evt_rdy,
    output logic          req_lvl,
    output logic [DW-1:0] req_data,
    input  logic          ack_sync,
    output logic          busy,
    output logic          ovf_err,
    output logic          to_err,
    input  logic          err_clr
);
    // state | meaning
    // IDLE  | nothing outstanding; launch FIFO head once ack_sync is low
    // REQ   | req_lvl high, waiting for ack_sync (or timeout)
    // REL   | req_lvl low, waiting for ack_sync to fall
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam int          TO_LAST_I = (TO_CYC == 0) ? 0 : TO_CYC - 1;
    localparam logic [15:0] TO_LAST   = 16'(TO_LAST_I);
    localparam bit          TO_EN     = (TO_CYC != 0);

    state_t        r_state;
    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic [15:0]   r_to_cnt;
    logic          r_req_lvl;
    logic [DW-1:0] r_req_data;
    logic          r_ovf_err;
    logic          r_to_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_timeout;

    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    assign w_push    = evt_vld && !w_full;
    // A drop is judged on the pre-pop count, so a simultaneous launch does not save the event.
    assign w_drop    = evt_vld && w_full;
    assign w_pop     = (r_state == IDLE) && !w_empty && !ack_sync;
    assign w_timeout = TO_EN && (r_state == REQ) && !ack_sync && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= evt_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= IDLE;
            r_req_lvl  <= 1'b0;
            r_req_data <= '0;
            r_to_cnt   <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_req_data <= r_mem[r_rptr];
                        r_req_lvl  <= 1'b1;
                        r_to_cnt   <= 16'd0;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                    if (ack_sync || w_timeout) begin
                        r_req_lvl <= 1'b0;
                        r_state   <= REL;
                    end
                end
                REL: begin
                    if (!ack_sync) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_req_lvl <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ovf_err <= 1'b0;
            r_to_err  <= 1'b0;
        end else begin
            r_ovf_err <= w_drop | (r_ovf_err & ~err_clr);
            r_to_err  <= w_timeout | (r_to_err & ~err_clr);
        end
    end

    assign evt_rdy  = !w_full;
    assign req_lvl  = r_req_lvl;
    assign req_data = r_req_data;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign ovf_err  = r_ovf_err;
    assign to_err   = r_to_err;

endmodule

// File: tb/tb_pa_dtu_cdc_hs_src.sv
// Bench for pa_dtu_cdc_hs_src: two instances (timeout off / TO_CYC=8) share stimulus and are
// checked every cycle against a queue-based handshake model, plus table and directed sequences.
module tb_pa_dtu_cdc_hs_src;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        evt_vld = 1'b0;
    logic [31:0] evt_data = '0;
    logic        ack_sync = 1'b0;
    logic        err_clr = 1'b0;

    logic        o_rdy  [2];
    logic        o_lvl  [2];
    logic [31:0] o_data [2];
    logic        o_busy [2];
    logic        o_ovf  [2];
    logic        o_toe  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pa_dtu_cdc_hs_src #(.DW(32), .TO_CYC(0)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .evt_vld(evt_vld), .evt_data(evt_data),
        .evt_rdy(o_rdy[0]), .req_lvl(o_lvl[0]), .req_data(o_data[0]),
        .ack_sync(ack_sync), .busy(o_busy[0]), .ovf_err(o_ovf[0]),
        .to_err(o_toe[0]), .err_clr(err_clr)
    );

    pa_dtu_cdc_hs_src #(.DW(32), .TO_CYC(8)) u_dut8 (
        .clk(clk), .rst_b(rst_b), .evt_vld(evt_vld), .evt_data(evt_data),
        .evt_rdy(o_rdy[1]), .req_lvl(o_lvl[1]), .req_data(o_data[1]),
        .ack_sync(ack_sync), .busy(o_busy[1]), .ovf_err(o_ovf[1]),
        .to_err(o_toe[1]), .err_clr(err_clr)
    );

    // Reference model: pending events as a queue, handshake phase 0=idle 1=request 2=release.
    logic [31:0] mq [2][$];
    int          mph  [2];
    int          mcnt [2];
    logic [31:0] mdat [2];
    logic        movf [2];
    logic        mtoe [2];

    function automatic int to_of(input int m);
        return (m == 0) ? 0 : 8;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mph[m]  = 0;
            mcnt[m] = 0;
            mdat[m] = '0;
            movf[m] = 1'b0;
            mtoe[m] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (!rst_b) return;
        for (int m = 0; m < 2; m++) begin
            int   sz;
            logic drop, launch, tmo, push;
            sz     = mq[m].size();
            drop   = evt_vld && (sz == 2);
            push   = evt_vld && (sz < 2);
            launch = (mph[m] == 0) && (sz > 0) && !ack_sync;
            tmo    = (mph[m] == 1) && !ack_sync && (to_of(m) != 0) && (mcnt[m] == to_of(m) - 1);
            if (launch) begin
                mdat[m] = mq[m].pop_front();
                mph[m]  = 1;
                mcnt[m] = 0;
            end else if (mph[m] == 1) begin
                if (ack_sync || tmo) mph[m] = 2;
                else mcnt[m]++;
            end else if (mph[m] == 2 && !ack_sync) begin
                mph[m] = 0;
            end
            if (push) mq[m].push_back(evt_data);
            movf[m] = drop || (movf[m] && !err_clr);
            mtoe[m] = tmo || (mtoe[m] && !err_clr);
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d req_lvl", m),  o_lvl[m],  mph[m] == 1);
            chk($sformatf("m%0d req_data", m), o_data[m], mdat[m]);
            chk($sformatf("m%0d evt_rdy", m),  o_rdy[m],  mq[m].size() != 2);
            chk($sformatf("m%0d busy", m),     o_busy[m], (mph[m] != 0) || (mq[m].size() != 0));
            chk($sformatf("m%0d ovf_err", m),  o_ovf[m],  movf[m]);
            chk($sformatf("m%0d to_err", m),   o_toe[m],  mtoe[m]);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic a, input logic c);
        evt_vld  = v;
        evt_data = d;
        ack_sync = a;
        err_clr  = c;
    endtask

    // Called at posedge+1: compare current outputs, advance one clock, advance the model.
    task automatic tick();
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, 1'b0);
        rst_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic deliver(input logic [31:0] exp);
        int n;
        n = 0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        while (o_lvl[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("deliver req wait", o_lvl[0], 1'b1);
        chk("deliver order", o_data[0], exp);
        ack_sync = 1'b1;
        n = 0;
        while (o_lvl[0] !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("deliver req release", o_lvl[0], 1'b0);
        ack_sync = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        ack;
        logic        e_lvl;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_busy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ra;

        // Single event: push at c0, request at c2, ack c6..c9, release c7, idle c11.
        tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0};

        do_reset();
        for (int m = 0; m < 2; m++) begin
            chk("reset req_lvl", o_lvl[m], 1'b0);
            chk("reset req_data", o_data[m], 32'h0);
            chk("reset evt_rdy", o_rdy[m], 1'b1);
            chk("reset busy", o_busy[m], 1'b0);
            chk("reset ovf_err", o_ovf[m], 1'b0);
            chk("reset to_err", o_toe[m], 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].vld, tbl[i].data, tbl[i].ack, 1'b0);
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("tbl%0d m%0d req_lvl", i, m), o_lvl[m], tbl[i].e_lvl);
                chk($sformatf("tbl%0d m%0d req_data", i, m), o_data[m], tbl[i].e_data);
                chk($sformatf("tbl%0d m%0d evt_rdy", i, m), o_rdy[m], tbl[i].e_rdy);
                chk($sformatf("tbl%0d m%0d busy", i, m), o_busy[m], tbl[i].e_busy);
            end
            tick();
        end

        // Back-to-back: three events, ack held off, delivered in order without overflow.
        do_reset();
        set_in(1'b1, 32'h1, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h2, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h3, 1'b0, 1'b0); tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        chk("b2b evt_rdy full", o_rdy[0], 1'b0);
        chk("b2b first in flight", o_data[0], 32'h1);
        tick(); tick();
        deliver(32'h1);
        deliver(32'h2);
        deliver(32'h3);
        chk("b2b ovf_err", o_ovf[0], 1'b0);
        chk("b2b busy drained", o_busy[0], 1'b0);

        // Overflow: fourth event dropped; clear works; clear + new drop keeps flag set.
        do_reset();
        set_in(1'b1, 32'h11, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h12, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h13, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h14, 1'b0, 1'b0);
        chk("ovf full before drop", o_rdy[0], 1'b0);
        chk("ovf not yet set", o_ovf[0], 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b1);
        chk("ovf set after drop", o_ovf[0], 1'b1);
        tick();
        set_in(1'b1, 32'h15, 1'b0, 1'b1);
        chk("ovf cleared", o_ovf[0], 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        chk("ovf set wins over clear", o_ovf[0], 1'b1);
        deliver(32'h11);
        deliver(32'h12);
        deliver(32'h13);
        chk("ovf drained", o_busy[0], 1'b0);

        // Timeout on the TO_CYC=8 instance, then an ack in the last counted cycle.
        do_reset();
        set_in(1'b1, 32'h21, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h22, 1'b0, 1'b0); tick();
        for (int c = 2; c <= 20; c++) begin
            set_in(1'b0, '0, (c == 19), (c == 12));
            if (c == 2)  chk("to rise", o_lvl[1], 1'b1);
            if (c == 9)  chk("to still high c9", o_lvl[1], 1'b1);
            if (c == 10) begin
                chk("to fall c10", o_lvl[1], 1'b0);
                chk("to_err set", o_toe[1], 1'b1);
                chk("no timeout when disabled", o_lvl[0], 1'b1);
            end
            if (c == 11) chk("to low c11", o_lvl[1], 1'b0);
            if (c == 12) begin
                chk("to relaunch c12", o_lvl[1], 1'b1);
                chk("to relaunch data", o_data[1], 32'h22);
            end
            if (c == 13) chk("to_err cleared", o_toe[1], 1'b0);
            if (c == 18) chk("to high c18", o_lvl[1], 1'b1);
            if (c == 20) begin
                chk("ack wins fall", o_lvl[1], 1'b0);
                chk("ack wins to_err", o_toe[1], 1'b0);
                chk("disabled to_err", o_toe[0], 1'b0);
            end
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick(); tick();

        // Stale ack blocks launch until it falls.
        do_reset();
        set_in(1'b1, 32'h41, 1'b1, 1'b0); tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk("stale ack holds req", o_lvl[0], 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        chk("stale ack still low", o_lvl[0], 1'b0);
        tick();
        chk("stale ack launch", o_lvl[0], 1'b1);
        chk("stale ack data", o_data[0], 32'h41);
        set_in(1'b0, '0, 1'b1, 1'b0); tick();
        set_in(1'b0, '0, 1'b0, 1'b0); tick(); tick();

        // Reset mid-handshake with two buffered events.
        do_reset();
        set_in(1'b1, 32'h31, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h32, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h33, 1'b0, 1'b0); tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        chk("pre-reset req", o_lvl[0], 1'b1);
        chk("pre-reset full", o_rdy[0], 1'b0);
        #2;
        rst_b = 1'b0;
        #1;
        model_reset();
        chk("async rst req_lvl", o_lvl[0], 1'b0);
        chk("async rst evt_rdy", o_rdy[0], 1'b1);
        chk("async rst busy", o_busy[0], 1'b0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("post-reset no launch", o_lvl[0], 1'b0);
            chk("post-reset idle", o_busy[0], 1'b0);
            tick();
        end

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        ra = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            set_in($urandom_range(0, 2) == 0, $urandom, ra, $urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
